rv16_mul_seq: RTL and testbench



---
 rtl/rv16_mul_seq_if.sv | 42 ++++
 rtl/rv16_mul_seq.sv | 127 ++++++++++++
 tb/tb_rv16_mul_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rv16_mul_seq_if.sv
// rtl/rv16_mul_seq_if.sv - request/response bundle for the rv16_mul_seq nibble-serial multiplier
//
// Signals (named from the multiplier's point of view):
//   start_in     request, sampled only while the multiplier is idle
//   op_in        00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1_mult_in  multiplicand (DATA bits)
//   rs2_mult_in  multiplier (DATA bits)
//   busy_out     operation in flight
//   done_out     one-cycle pulse, rd_mult_out valid in that cycle
//   rd_mult_out  result, held until the next done
// Modports: master drives the request side (decode/execute), slave is the multiplier.
interface rv16_mul_seq_if #(
   parameter int DATA = 16
);
   logic            start_in;
   logic [1:0]      op_in;
   logic [DATA-1:0] rs1_mult_in;
   logic [DATA-1:0] rs2_mult_in;
   logic            busy_out;
   logic            done_out;
   logic [DATA-1:0] rd_mult_out;

   modport master (
      output start_in,
      output op_in,
      output rs1_mult_in,
      output rs2_mult_in,
      input  busy_out,
      input  done_out,
      input  rd_mult_out
   );

   modport slave (
      input  start_in,
      input  op_in,
      input  rs1_mult_in,
      input  rs2_mult_in,
      output busy_out,
      output done_out,
      output rd_mult_out
   );
endinterface

// File: rtl/rv16_mul_seq.sv
// rtl/rv16_mul_seq.sv - sequential nibble-serial M-extension multiplier for the RV16 execute stage
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous, active-low reset
//   mul_bus  rv16_mul_seq_if.slave: start_in/op_in/rs1_mult_in/rs2_mult_in in,
//            busy_out/done_out/rd_mult_out out
// Operation: operands are converted to magnitudes on accept, one 4-bit digit of
// |rs2| is multiplied against |rs1| and accumulated per CALC cycle, and the FIX
// cycle applies the sign and selects the requested half.
// Optional build macro: RV16_MUL_EARLY_EXIT_EN - leave CALC as soon as the
// remaining multiplier digits are all zero (result unchanged, latency shorter).
module rv16_mul_seq #(
   parameter int DATA = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   rv16_mul_seq_if.slave  mul_bus
);

   localparam int DIGITS = DATA / 4;
   localparam int ACC_W  = 2 * DATA;
   localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX
   } state_t;

   state_t           r_state;
   logic [1:0]       r_op;
   logic             r_neg;
   logic [ACC_W-1:0] r_mcand;   // |rs1|, pre-shifted by 4k so each partial product lands in place
   logic [DATA-1:0]  r_mplr;    // |rs2|, shifted right so the current digit is always [3:0]
   logic [ACC_W-1:0] r_acc;
   logic [KW-1:0]    r_k;
   logic             r_busy;
   logic             r_done;
   logic [DATA-1:0]  r_rd;

   logic             w_sgn1;
   logic             w_sgn2;
   logic [DATA-1:0]  w_mag1;
   logic [DATA-1:0]  w_mag2;
   logic [3:0]       w_digit;
   logic [ACC_W-1:0] w_pp;
   logic [ACC_W-1:0] w_prod;
   logic             w_last;

   // rs1 is signed for MULH and MULHSU, rs2 only for MULH. MUL takes the raw
   // bit patterns as unsigned, the low half being identical either way.
   assign w_sgn1 = ((mul_bus.op_in == 2'b01) || (mul_bus.op_in == 2'b10)) &&
                   mul_bus.rs1_mult_in[DATA-1];
   assign w_sgn2 = (mul_bus.op_in == 2'b01) && mul_bus.rs2_mult_in[DATA-1];

   // 0x8000 negates to itself, which is exactly its unsigned magnitude.
   assign w_mag1 = w_sgn1 ? (DATA'(0) - mul_bus.rs1_mult_in) : mul_bus.rs1_mult_in;
   assign w_mag2 = w_sgn2 ? (DATA'(0) - mul_bus.rs2_mult_in) : mul_bus.rs2_mult_in;

   assign w_digit = r_mplr[3:0];
   // r_mcand < 2^(DATA+4k) and digit < 16, so the product fits ACC_W bits.
   assign w_pp    = r_mcand * ACC_W'(w_digit);
   assign w_prod  = r_neg ? (ACC_W'(0) - r_acc) : r_acc;

`ifdef RV16_MUL_EARLY_EXIT_EN
   // Digits above the one consumed this cycle; when all zero the rest of CALC adds nothing.
   assign w_last = (r_k == KW'(DIGITS - 1)) || (r_mplr[DATA-1:4] == '0);
`else
   assign w_last = (r_k == KW'(DIGITS - 1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_op    <= 2'b00;
         r_neg   <= 1'b0;
         r_mcand <= '0;
         r_mplr  <= '0;
         r_acc   <= '0;
         r_k     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_rd    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (mul_bus.start_in) begin
                  r_op    <= mul_bus.op_in;
                  r_neg   <= w_sgn1 ^ w_sgn2;
                  r_mcand <= ACC_W'(w_mag1);
                  r_mplr  <= w_mag2;
                  r_acc   <= '0;
                  r_k     <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_CALC;
               end
            end
            ST_CALC: begin
               r_acc   <= r_acc + w_pp;
               r_mcand <= r_mcand << 4;
               r_mplr  <= r_mplr >> 4;
               r_k     <= r_k + KW'(1);
               if (w_last) begin
                  r_state <= ST_FIX;
               end
            end
            ST_FIX: begin
               r_rd    <= (r_op == 2'b00) ? w_prod[DATA-1:0] : w_prod[ACC_W-1:DATA];
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign mul_bus.busy_out    = r_busy;
   assign mul_bus.done_out    = r_done;
   assign mul_bus.rd_mult_out = r_rd;

endmodule

// File: tb/tb_rv16_mul_seq.sv
// tb/tb_rv16_mul_seq.sv - scoreboard bench for rv16_mul_seq with directed, hand-computed vectors
module tb_rv16_mul_seq;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_pass;
   int   n_total;

   logic [15:0] exp_q[$];
   int          expcyc_q[$];

   rv16_mul_seq_if #(.DATA(16)) mif ();

   rv16_mul_seq #(.DATA(16)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .mul_bus (mif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cyc);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && mif.done_out) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [15:0] e;
            int          ec;
            e  = exp_q.pop_front();
            ec = expcyc_q.pop_front();
            chk("result", 32'(mif.rd_mult_out), 32'(e));
            chk("done_cycle", 32'(cyc), 32'(ec));
         end
      end
   end

   // Drive one request; accepted at the following rising edge (edge N).
   task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input int lat_e, input bit now, input bit push);
      int lat;
`ifdef RV16_MUL_EARLY_EXIT_EN
      lat = lat_e;
`else
      lat = 5;
`endif
      if (!now) @(negedge clk);
      mif.op_in       = op;
      mif.rs1_mult_in = a;
      mif.rs2_mult_in = b;
      mif.start_in    = 1'b1;
      @(posedge clk);
      #1;
      mif.start_in = 1'b0;
      if (push) begin
         exp_q.push_back(exp_res);
         expcyc_q.push_back(cyc + lat);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
         exp_q.delete();
         expcyc_q.delete();
      end
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      int          lat_e;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      n_pass = 0;
      n_total = 0;
      cyc = 0;
      rst_n = 1'b0;
      mif.start_in = 1'b0;
      mif.op_in = 2'b00;
      mif.rs1_mult_in = '0;
      mif.rs2_mult_in = '0;
`ifdef RV16_MUL_EARLY_EXIT_EN
      lat = 2;
`else
      lat = 5;
`endif

      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(mif.busy_out), 32'd0);
      chk("reset_done", 32'(mif.done_out), 32'd0);
      chk("reset_rd", 32'(mif.rd_mult_out), 32'd0);
      rst_n = 1'b1;

      // MUL 3x5 with busy profile: high after accept until the done edge.
      issue(2'b00, 16'h0003, 16'h0005, 16'h000F, 2, 1'b0, 1'b1);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         chk("busy_in_flight", 32'(mif.busy_out), 32'd1);
      end
      @(negedge clk);
      chk("busy_at_done", 32'(mif.busy_out), 32'd0);
      drain();

      vecs.push_back('{2'b01, 16'hFFFF, 16'h0002, 16'hFFFF, 2});
      vecs.push_back('{2'b00, 16'hFFFF, 16'h0002, 16'hFFFE, 2});
      vecs.push_back('{2'b11, 16'hFFFF, 16'hFFFF, 16'hFFFE, 5});
      vecs.push_back('{2'b10, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5});
      vecs.push_back('{2'b01, 16'h8000, 16'h8000, 16'h4000, 5});
      vecs.push_back('{2'b01, 16'hFFFE, 16'h0003, 16'hFFFF, 2});
      vecs.push_back('{2'b00, 16'hFFFE, 16'h0003, 16'hFFFA, 2});
      vecs.push_back('{2'b00, 16'h1234, 16'h0003, 16'h369C, 2});
      vecs.push_back('{2'b00, 16'h0001, 16'h1000, 16'h1000, 5});
      vecs.push_back('{2'b11, 16'h00FF, 16'h0010, 16'h0000, 3});
      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat_e, 1'b0, 1'b1);
         drain();
      end

      // Start while busy is ignored; start in the done cycle is accepted.
      issue(2'b00, 16'h0007, 16'h0009, 16'h003F, 2, 1'b0, 1'b1);
      @(negedge clk);
      mif.rs1_mult_in = 16'h1234;
      mif.rs2_mult_in = 16'h0010;
      mif.start_in = 1'b1;
      @(negedge clk);
      mif.start_in = 1'b0;
      begin
         int t;
         t = 0;
         while (!mif.done_out && t < 20) begin
            @(negedge clk);
            t++;
         end
         chk("done_seen_for_b2b", 32'(mif.done_out), 32'd1);
      end
      issue(2'b00, 16'h0002, 16'h0003, 16'h0006, 2, 1'b1, 1'b1);
      drain();
      repeat (3) @(negedge clk);

      // Reset mid-operation: outputs clear at once and no done follows.
      issue(2'b00, 16'h00FF, 16'h00FF, 16'h0000, 3, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("busy_before_reset", 32'(mif.busy_out), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_busy", 32'(mif.busy_out), 32'd0);
      chk("async_reset_done", 32'(mif.done_out), 32'd0);
      chk("async_reset_rd", 32'(mif.rd_mult_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      issue(2'b00, 16'h0002, 16'h0002, 16'h0004, 2, 1'b0, 1'b1);
      drain();
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
